// File: rtl/ttt_pkg.sv
// Shared tic-tac-toe definitions: game-state codes, FSM states, the line table
// and the preferred-move order used by the auto player.
package ttt_pkg;

  typedef enum logic [1:0] {
    PLAYING = 2'b00,
    WIN_O   = 2'b01,
    WIN_X   = 2'b10,
    DRAW    = 2'b11
  } game_state_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN_WIN,
    S_SCAN_BLOCK,
    S_SCAN_PREF,
    S_ISSUE,
    S_WAIT
  } state_e;

  typedef logic [3:0] cell_t;

  localparam int    NUM_CELLS = 9;
  localparam int    NUM_LINES = 8;
  localparam cell_t LAST_POS  = 4'd8;

  // Rows, columns, then the two diagonals; cell index = row*3 + col.
  localparam cell_t LINE_TABLE [NUM_LINES][3] = '{
    '{4'd0, 4'd1, 4'd2},
    '{4'd3, 4'd4, 4'd5},
    '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6},
    '{4'd1, 4'd4, 4'd7},
    '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8},
    '{4'd2, 4'd4, 4'd6}
  };

  // Centre first, then corners, then edges.
  localparam cell_t PREF_ORDER [NUM_CELLS] = '{
    4'd4, 4'd0, 4'd2, 4'd6, 4'd8, 4'd1, 4'd3, 4'd5, 4'd7
  };

  function automatic logic cell_owned(input logic [8:0] valid,
                                      input logic [8:0] symbol,
                                      input cell_t      c,
                                      input logic       target);
    return valid[c] && (symbol[c] == target);
  endfunction

  function automatic logic [1:0] cell_row(input cell_t c);
    logic [1:0] r;
    case (c)
      4'd0, 4'd1, 4'd2: r = 2'd0;
      4'd3, 4'd4, 4'd5: r = 2'd1;
      default:          r = 2'd2;
    endcase
    return r;
  endfunction

  function automatic logic [1:0] cell_col(input cell_t c);
    logic [1:0] k;
    case (c)
      4'd0, 4'd3, 4'd6: k = 2'd0;
      4'd1, 4'd4, 4'd7: k = 2'd1;
      default:          k = 2'd2;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/ttt_line_probe.sv
// Per-cell line test: the cell is free and some line through it already holds
// two cells of target_symbol.
module ttt_line_probe
  import ttt_pkg::*;
(
  input  logic [3:0] idx,
  input  logic [8:0] valid,
  input  logic [8:0] symbol,
  input  logic       target_symbol,
  output logic       hit
);

  logic w_line_hit;

  always_comb begin
    // NOTE: a default before the loop keeps every path assigned, so no latch is inferred.
    w_line_hit = 1'b0;
    for (int l = 0; l < NUM_LINES; l++) begin
      if ((LINE_TABLE[l][0] == idx &&
           cell_owned(valid, symbol, LINE_TABLE[l][1], target_symbol) &&
           cell_owned(valid, symbol, LINE_TABLE[l][2], target_symbol)) ||
          (LINE_TABLE[l][1] == idx &&
           cell_owned(valid, symbol, LINE_TABLE[l][0], target_symbol) &&
           cell_owned(valid, symbol, LINE_TABLE[l][2], target_symbol)) ||
          (LINE_TABLE[l][2] == idx &&
           cell_owned(valid, symbol, LINE_TABLE[l][0], target_symbol) &&
           cell_owned(valid, symbol, LINE_TABLE[l][1], target_symbol))) begin
        w_line_hit = 1'b1;
      end
    end
  end

  assign hit = !valid[idx] && w_line_hit;

endmodule

// File: rtl/ttt_auto_player.sv
// Automatic tic-tac-toe player: scans for a winning move, then a blocking move,
// then the preferred free cell, issues it to the board and waits for acceptance.
module ttt_auto_player
  import ttt_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       my_symbol,
  input  logic [8:0] valid,
  input  logic [8:0] symbol,
  input  logic [1:0] game_state,
  output logic [1:0] row,
  output logic [1:0] col,
  output logic       set,
  output logic       busy,
  output logic       done,
  output logic       no_move,
  output logic       err
);

  state_e     r_state;
  cell_t      r_cnt;
  logic [1:0] r_wait_cnt;
  cell_t      r_idx;
  logic [1:0] r_row;
  logic [1:0] r_col;
  logic       r_set;
  logic       r_busy;
  logic       r_done;
  logic       r_no_move;
  logic       r_err;

  cell_t      w_cur_idx;
  logic       w_win_hit;
  logic       w_block_hit;
  logic       w_hit;
  logic       w_playing;

  assign w_cur_idx = (r_state == S_SCAN_PREF) ? PREF_ORDER[r_cnt] : r_cnt;
  assign w_playing = (game_state == PLAYING);

  ttt_line_probe u_probe_win (
    .idx           (w_cur_idx),
    .valid         (valid),
    .symbol        (symbol),
    .target_symbol (my_symbol),
    .hit           (w_win_hit)
  );

  ttt_line_probe u_probe_block (
    .idx           (w_cur_idx),
    .valid         (valid),
    .symbol        (symbol),
    .target_symbol (~my_symbol),
    .hit           (w_block_hit)
  );

  assign w_hit = (r_state == S_SCAN_WIN   && w_win_hit)   ||
                 (r_state == S_SCAN_BLOCK && w_block_hit) ||
                 (r_state == S_SCAN_PREF  && !valid[w_cur_idx]);

  // NOTE: the async reset clears every flop, so a reset mid-move leaves no pending strobe or pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_wait_cnt <= '0;
      r_idx      <= '0;
      r_row      <= '0;
      r_col      <= '0;
      r_set      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_no_move  <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here; the defaults below make every strobe a single-cycle pulse.
      r_set     <= 1'b0;
      r_done    <= 1'b0;
      r_no_move <= 1'b0;
      r_err     <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_playing) begin
              r_state <= S_SCAN_WIN;
              r_cnt   <= '0;
              r_busy  <= 1'b1;
            end else begin
              r_no_move <= 1'b1;
            end
          end
        end

        S_SCAN_WIN, S_SCAN_BLOCK, S_SCAN_PREF: begin
          if (!w_playing) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_no_move <= 1'b1;
            r_cnt     <= '0;
          end else if (w_hit) begin
            r_idx   <= w_cur_idx;
            r_row   <= cell_row(w_cur_idx);
            r_col   <= cell_col(w_cur_idx);
            r_set   <= 1'b1;
            r_state <= S_ISSUE;
            r_cnt   <= '0;
          end else if (r_cnt == LAST_POS) begin
            r_cnt <= '0;
            if (r_state == S_SCAN_WIN) begin
              r_state <= S_SCAN_BLOCK;
            end else if (r_state == S_SCAN_BLOCK) begin
              r_state <= S_SCAN_PREF;
            end else begin
              r_state   <= S_IDLE;
              r_busy    <= 1'b0;
              r_no_move <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end

        S_ISSUE: begin
          r_state    <= S_WAIT;
          r_wait_cnt <= '0;
        end

        S_WAIT: begin
          if (valid[r_idx]) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else if (r_wait_cnt == 2'd3) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_err   <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + 2'd1;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign row     = r_row;
  assign col     = r_col;
  assign set     = r_set;
  assign busy    = r_busy;
  assign done    = r_done;
  assign no_move = r_no_move;
  assign err     = r_err;

endmodule

// File: doc/ttt_auto_player.md
TTT_AUTO_PLAYER -- requirements
Module: ttt_auto_player

Interface
REQ-001 SHALL use one clock and one reset: the clock port is clk; reset is asynchronous and active-high and its port is reset.
REQ-002 SHALL have ports (name direction width meaning):
- clk  in  1  rising-edge clock
- reset  in  1  async active-high reset
- start  in  1  request one move from this player
- my_symbol  in  1  symbol this player places (1 = X, 0 = O)
- valid  in  9  board occupancy, index = row*3+col
- symbol  in  9  board symbols, meaningful where valid=1
- game_state  in  2  00 playing, 01/10 win, 11 draw
- row  out  2  move row 0..2
- col  out  2  move column 0..2
- set  out  1  one-cycle move strobe to the board
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse: move accepted by the board
- no_move  out  1  one-cycle pulse: no move possible, or aborted
- err  out  1  one-cycle pulse: board did not accept the issued move

Function
REQ-003 SHALL implement FSM states IDLE, SCAN_WIN, SCAN_BLOCK, SCAN_PREF, ISSUE, WAIT.
REQ-004 SHALL behave as follows in IDLE on start=1:
- game_state==00: go to SCAN_WIN with scan counter=0.
- otherwise: pulse no_move next cycle and stay in IDLE.
REQ-005 SHALL treat start as ignored whenever busy=1.
REQ-006 SHALL evaluate exactly one cell index per cycle while in a SCAN state, with the scan counter running 0..8.
REQ-007 SHALL count a cell as a SCAN_WIN hit when it is free and some line through it has both other cells valid with symbol==my_symbol.
REQ-008 SHALL count a cell as a SCAN_BLOCK hit under the same condition as REQ-007 but with symbol==~my_symbol.
REQ-009 SHALL define SCAN_PREF as visiting indices in the order 4,0,2,6,8,1,3,5,7 (scan counter position p); a hit is the first free cell in that order.
REQ-010 SHALL, on a hit, latch the hit index, drive row=idx/3 and col=idx%3, and enter ISSUE the next cycle.
REQ-011 SHALL, when a SCAN state reaches position 8 with no hit, advance to the next SCAN state with counter=0.
REQ-012 SHALL, when SCAN_PREF finishes with no hit (board full), pulse no_move and return to IDLE.
REQ-013 SHALL, in ISSUE, assert set=1 for exactly one cycle and then enter WAIT.
REQ-014 SHALL, in WAIT, use a 2-bit timeout counter:
- valid[idx]==1 within 4 cycles: pulse done and return to IDLE.
- otherwise: pulse err and return to IDLE.
REQ-015 SHALL abort from any SCAN state to IDLE with a no_move pulse whenever game_state!=00.
REQ-016 SHALL hold row and col stable from ISSUE until the next hit.
REQ-017 SHALL never assert set outside ISSUE.
REQ-018 SHALL never assert more than one of done, no_move, err in the same cycle.

Reset
REQ-019 SHALL, on reset=1, immediately and asynchronously force state=IDLE, counters=0, row=0, col=0, and set=busy=done=no_move=err=0.
REQ-020 SHALL, when reset is asserted mid-scan or mid-ISSUE, produce no set pulse and no status pulse afterwards.

Structure
REQ-021 SHALL place the following in a shared package ttt_pkg:
- game_state encodings (PLAYING=00, WIN_O=01, WIN_X=10, DRAW=11)
- the 8-entry line table
- the SCAN_PREF order table
REQ-022 SHALL implement the per-cell line test in one combinational sub-module ttt_line_probe with inputs idx, valid, symbol, target_symbol and output hit; it is instantiated twice (win/block) or muxed.

Verification
REQ-023 SHALL cover these directed scenarios:
- Empty board, my_symbol=1, start at cycle 0 -> set high at cycle 20 with row=1, col=1; board writes valid[4] -> done.
- X at cells 0,1, O at 3,4, my_symbol=1 -> SCAN_WIN hit index 2 -> set at cycle 4 with row=0, col=2.
- O at cells 0,4, X at 2, my_symbol=1 -> no win, block at index 8 -> set at cycle 19 with row=2, col=2.
- Full board, game_state=00 -> no_move after 27 scan cycles, set never asserted.
- Board never updates valid after set -> err pulse 4 cycles after WAIT entry.
- game_state goes to 10 mid-SCAN_BLOCK -> no_move next cycle, busy=0; reset asserted during ISSUE -> set drops immediately.
